vl_equiv_mismatch_logger: RTL

//  Consumer end of the spec-vs-impl equivalence flow. Accepts per-sample records {stimulus,

---
 rtl/vl_equiv_mismatch_logger_pkg.sv | 29 ++
 rtl/vl_equiv_mismatch_logger_if.sv | 33 +++
 rtl/vl_equiv_mismatch_logger_fifo.sv | 54 +++++
 rtl/vl_equiv_mismatch_logger.sv | 82 ++++++++
 4 files changed

// File: rtl/vl_equiv_mismatch_logger_pkg.sv
// Shared definitions for the equivalence mismatch logger: 4-state codes,
// default record layout and the encoded-vector compare.
package vl_equiv_pkg;

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VX = 2'b10;
  localparam logic [1:0] VZ = 2'b11;

  localparam int CODE_MAX_W = 64;
  localparam int DEF_IN_W   = 8;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_CNT_W  = 16;

  typedef struct packed {
    logic [2*DEF_IN_W-1:0]  stim;
    logic [2*DEF_OUT_W-1:0] spec;
    logic [2*DEF_OUT_W-1:0] impl;
    logic [DEF_CNT_W-1:0]   idx;
  } rec_t;

  // Case-inequality on encoded vectors: any differing code bit is a mismatch,
  // so X/X and Z/Z compare equal while X/Z does not.
  function automatic logic case_neq(input logic [CODE_MAX_W-1:0] a,
                                    input logic [CODE_MAX_W-1:0] b);
    return |(a ^ b);
  endfunction

endpackage

// File: rtl/vl_equiv_mismatch_logger_if.sv
// Sample-in / mismatch-out handshake bundle plus the running counters.
interface vl_equiv_mismatch_logger_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
);
  logic                 chk_valid;
  logic                 chk_ready;
  logic [2*IN_W-1:0]    chk_stim;
  logic [2*OUT_W-1:0]   chk_spec;
  logic [2*OUT_W-1:0]   chk_impl;
  logic                 log_valid;
  logic                 log_ready;
  logic [2*IN_W-1:0]    log_stim;
  logic [2*OUT_W-1:0]   log_spec;
  logic [2*OUT_W-1:0]   log_impl;
  logic [CNT_W-1:0]     log_idx;
  logic [CNT_W-1:0]     n_checked;
  logic [CNT_W-1:0]     n_failed;
  logic [CNT_W-1:0]     n_dropped;

  modport master (
    output chk_valid, chk_stim, chk_spec, chk_impl, log_ready,
    input  chk_ready, log_valid, log_stim, log_spec, log_impl, log_idx,
           n_checked, n_failed, n_dropped
  );

  modport slave (
    input  chk_valid, chk_stim, chk_spec, chk_impl, log_ready,
    output chk_ready, log_valid, log_stim, log_spec, log_impl, log_idx,
           n_checked, n_failed, n_dropped
  );
endinterface

// File: rtl/vl_equiv_mismatch_logger_fifo.sv
// First-word-fall-through FIFO; accepts a write while full when the head is
// popped in the same cycle.
module vl_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign pop      = rd_valid & rd_ready & ~clear;
  assign wr_ready = ~full | pop;
  assign push     = wr_valid & wr_ready & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/vl_equiv_mismatch_logger.sv
// Compares encoded spec/impl samples, logs mismatches into a FIFO and keeps
// saturating checked/failed/dropped counts.
module vl_equiv_mismatch_logger
  import vl_equiv_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  parameter int STALL = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  vl_equiv_mismatch_logger_if.slave   bus
);
  localparam int SW = 2*IN_W;
  localparam int OW = 2*OUT_W;
  localparam int RW = SW + 2*OW + CNT_W;

  typedef struct packed {
    logic [SW-1:0]    stim;
    logic [OW-1:0]    spec;
    logic [OW-1:0]    impl;
    logic [CNT_W-1:0] idx;
  } log_rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] checked_q, failed_q, dropped_q;
  logic             full, fifo_wr_ready, acc, mism, push, drop;
  log_rec_t         wr_rec, rd_rec;

  assign bus.chk_ready = (STALL != 0) ? ~full : 1'b1;
  assign acc  = bus.chk_valid & bus.chk_ready & ~clear;
  assign mism = case_neq(CODE_MAX_W'(bus.chk_spec), CODE_MAX_W'(bus.chk_impl));
  assign push = acc & mism;
  // Only reachable without back-pressure: full and no pop this cycle.
  assign drop = push & ~fifo_wr_ready;

  assign wr_rec = '{stim: bus.chk_stim, spec: bus.chk_spec,
                    impl: bus.chk_impl, idx: checked_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checked_q <= '0;
      failed_q  <= '0;
      dropped_q <= '0;
    end else if (clear) begin
      checked_q <= '0;
      failed_q  <= '0;
      dropped_q <= '0;
    end else if (acc) begin
      checked_q <= sat_inc(checked_q);
      if (mism) failed_q  <= sat_inc(failed_q);
      if (drop) dropped_q <= sat_inc(dropped_q);
    end
  end

  vl_sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .wr_valid (push),
    .wr_ready (fifo_wr_ready),
    .wr_data  (wr_rec),
    .rd_valid (bus.log_valid),
    .rd_ready (bus.log_ready),
    .rd_data  (rd_rec),
    .full     (full)
  );

  assign bus.log_stim  = rd_rec.stim;
  assign bus.log_spec  = rd_rec.spec;
  assign bus.log_impl  = rd_rec.impl;
  assign bus.log_idx   = rd_rec.idx;
  assign bus.n_checked = checked_q;
  assign bus.n_failed  = failed_q;
  assign bus.n_dropped = dropped_q;
endmodule
